// File: rtl/datapath_unpack_fifo.sv
// Word FIFO of 192-bit packed entries that unpacks each word into two 128-bit
// output beats ({B,A} then {0,C}) through a registered holding stage.
module datapath_unpack_fifo #(
    parameter int DEPTH      = 1024,
    parameter int DEPTH_SIZE = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr,
    input  logic [191:0]          data_in,
    input  logic                  clr_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [127:0]          m_data,
    output logic                  m_last,
    output logic [DEPTH_SIZE:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  threshold,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    localparam logic [DEPTH_SIZE:0] HALF = (DEPTH_SIZE+1)'(DEPTH / 2);

    logic [191:0]        mem [DEPTH];
    logic [DEPTH_SIZE:0] wr_ptr, rd_ptr;
    logic [191:0]        hold;
    state_t              state, state_nxt;
    logic                wr_en, load;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full      = (wr_ptr[DEPTH_SIZE] != rd_ptr[DEPTH_SIZE]) &&
                       (wr_ptr[DEPTH_SIZE-1:0] == rd_ptr[DEPTH_SIZE-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign wr_en     = wr && !full;
    assign threshold = (data_count >= HALF);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[DEPTH_SIZE-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            overflow   <= 1'b0;
            state      <= IDLE;
            hold       <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            // The holding register is the registered RAM read port.
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr[DEPTH_SIZE-1:0]];
            end
            case ({wr_en, load})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
            if (wr && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                m_valid = 1'b1;
                m_data  = hold[127:0];
                if (m_ready)
                    state_nxt = BEAT1;
            end
            BEAT1: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = {64'b0, hold[191:128]};
                // Reload on the final handshake so consecutive words stream without a bubble.
                if (m_ready) begin
                    if (!empty) begin
                        load      = 1'b1;
                        state_nxt = BEAT0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_unpack_fifo.sv
// Scoreboard bench for datapath_unpack_fifo: expected beats queued on write,
// compared by a negedge monitor on every output handshake.
module tb_datapath_unpack_fifo;

    localparam int DEPTH      = 1024;
    localparam int DEPTH_SIZE = 10;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                wr = 1'b0;
    logic [191:0]        data_in = '0;
    logic                clr_err = 1'b0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [127:0]        m_data;
    logic                m_last;
    logic [DEPTH_SIZE:0] data_count;
    logic                full, empty, threshold, overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    int beat_cnt = 0;
    int run_len = 0;
    logic prev_beat = 1'b0;
    logic [128:0] sb [$];

    datapath_unpack_fifo #(.DEPTH(DEPTH), .DEPTH_SIZE(DEPTH_SIZE)) dut (
        .clk(clk), .rstn(rstn), .wr(wr), .data_in(data_in), .clr_err(clr_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .data_count(data_count), .full(full), .empty(empty),
        .threshold(threshold), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] mkword(input int unsigned i);
        return {32'hCCCC_0000, i, 32'hBBBB_0000, i, 32'hAAAA_0000, i};
    endfunction

    task automatic push_word(input logic [191:0] w);
        sb.push_back({1'b0, w[127:0]});
        sb.push_back({1'b1, 64'b0, w[191:128]});
    endtask

    task automatic wr_word(input logic [191:0] w);
        wr = 1'b1;
        data_in = w;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_count", data_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_threshold", threshold, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        m_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 192'(sb.size()), 0);
    endtask

    // Beats are compared where the handshake is decided, just before the rising edge.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (sb.size() == 0)
                chk("spurious_beat", {m_last, m_data}, 0);
            else
                chk("beat", {m_last, m_data}, sb.pop_front());
            beat_cnt <= beat_cnt + 1;
            run_len  <= prev_beat ? run_len + 1 : 1;
        end
        prev_beat <= rstn && m_valid && m_ready;
    end

    initial begin
        logic [191:0] w;
        int base, n, guard;
        logic seen_hi;

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_reset_state();
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single word with the sink always ready
        m_ready = 1'b1;
        w = {64'hC, 64'hB, 64'hA};
        push_word(w);
        wr_word(w);
        chk("lat_idle", m_valid, 0);
        @(posedge clk); #1;
        chk("b0_valid", m_valid, 1);
        chk("b0_data", {m_last, m_data}, {1'b0, 64'hB, 64'hA});
        @(posedge clk); #1;
        chk("b1_data", {m_valid, m_last, m_data}, {2'b11, 64'h0, 64'hC});
        @(posedge clk); #1;
        chk("after_valid", m_valid, 0);
        chk("after_empty", empty, 1);

        // Backpressure during BEAT0
        m_ready = 1'b0;
        w = mkword(32'h55);
        push_word(w);
        wr_word(w);
        @(posedge clk); #1;
        repeat (5) begin
            chk("bp_hold", {m_valid, m_last, m_data}, {2'b10, w[127:0]});
            @(posedge clk); #1;
        end
        drain(20);

        // Fill to full with the sink stalled
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w = mkword(i);
            push_word(w);
            wr_word(w);
            if (i == DEPTH/2 - 1) begin
                chk("thr_below", {threshold, 181'(data_count)}, {1'b0, 181'(DEPTH/2 - 1)});
            end
            if (i == DEPTH/2) begin
                chk("thr_at", {threshold, 181'(data_count)}, {1'b1, 181'(DEPTH/2)});
            end
        end
        chk("fill_count", data_count, DEPTH - 1);
        chk("fill_not_full", full, 0);
        w = mkword(DEPTH);
        push_word(w);
        wr_word(w);
        chk("full_set", full, 1);
        chk("full_count", data_count, DEPTH);
        wr_word(mkword(32'hDEAD));
        chk("ovf_set", overflow, 1);
        chk("ovf_count", data_count, DEPTH);
        wr = 1'b1; clr_err = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("ovf_cleared", overflow, 0);
        drain(3000);
        chk("fill_drained_empty", {m_valid, empty}, 2'b01);

        // Continuous stream across pointer wrap
        do_reset();
        seen_hi = 1'b0;
        base = beat_cnt;
        n = 0;
        guard = 0;
        m_ready = 1'b1;
        while (n < 2*DEPTH && guard < 20000) begin
            if (!full) begin
                w = mkword(n);
                wr = 1'b1;
                data_in = w;
                push_word(w);
                n++;
            end else begin
                wr = 1'b0;
            end
            if (threshold) seen_hi = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        wr = 1'b0;
        chk("stream_writes", n, 2*DEPTH);
        drain(6000);
        chk("stream_beats", beat_cnt - base, 4*DEPTH);
        chk("stream_no_gap", run_len, 4*DEPTH);
        chk("stream_thr_hi", seen_hi, 1);
        chk("stream_thr_lo", threshold, 0);

        // Write coincident with a BEAT1 handshake
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = mkword(100 + i);
            push_word(w);
            wr_word(w);
        end
        chk("sim_count0", data_count, 3);
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("sim_in_b1", {m_valid, m_last, 11'(data_count)}, {2'b11, 11'd3});
        w = mkword(104);
        push_word(w);
        wr = 1'b1;
        data_in = w;
        @(posedge clk); #1;
        wr = 1'b0;
        m_ready = 1'b0;
        w = mkword(101);
        chk("sim_count", data_count, 3);
        chk("sim_next_b0", {m_valid, m_last, m_data}, {2'b10, w[127:0]});
        drain(30);

        // Asynchronous reset while in BEAT1 with ten words stored
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            w = mkword(200 + i);
            push_word(w);
            wr_word(w);
        end
        chk("mid_count", data_count, 10);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("mid_in_b1", {m_valid, m_last}, 2'b11);
        #2 rstn = 1'b0;
        sb.delete();
        #1 chk_reset_state();
        @(posedge clk); #1;
        rstn = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_stale", {m_valid, empty}, 2'b01);
        w = mkword(32'h777);
        push_word(w);
        wr_word(w);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
